// File: rtl/dma_copy_seq.sv
// -----------------------------------------------------------------------------
// dma_copy_seq
//   Memory-to-memory copy sequencer placed in front of the AXI DMA bridge.
//   It takes one copy command (source, destination and beat count) and splits
//   it into read bursts. Each read burst is staged in a local beat buffer and
//   then replayed as a write burst. Bursts never cross a 4 KB page on either
//   the source or the destination side. A bus error is sticky: the burst in
//   flight still completes, but any remaining bursts are skipped.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready       copy command handshake (src, dst, beats)
//   o_busy, o_done, o_err     status: busy level, done pulse, sticky error
//   o_req_mem_*               bridge request channel (read burst / write beats)
//   i_resp_mem_*/o_resp_mem_ready
//                             bridge response channel (read data / write ack)
// -----------------------------------------------------------------------------
module dma_copy_seq #(
    parameter int abits     = 48,
    parameter int MAX_BURST = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [abits-1:0] i_cmd_src,
    input  logic [abits-1:0] i_cmd_dst,
    input  logic [15:0]      i_cmd_beats,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_req_mem_valid,
    input  logic             i_req_mem_ready,
    output logic             o_req_mem_write,
    output logic [abits-1:0] o_req_mem_addr,
    output logic [2:0]       o_req_mem_size,
    output logic [7:0]       o_req_mem_len,
    output logic [63:0]      o_req_mem_wdata,
    output logic [7:0]       o_req_mem_wstrb,
    output logic             o_req_mem_last,
    input  logic             i_resp_mem_valid,
    input  logic [63:0]      i_resp_mem_data,
    input  logic             i_resp_mem_err,
    output logic             o_resp_mem_ready
);

    // Chunk/index width: must hold the value MAX_BURST itself.
    localparam int CW = $clog2(MAX_BURST) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_DATA = 3'd3;
    localparam logic [2:0] S_WR_REQ  = 3'd4;
    localparam logic [2:0] S_WR_RESP = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [abits-1:0] src_q, src_d;
    logic [abits-1:0] dst_q, dst_d;
    logic [15:0]      remaining_q, remaining_d;
    logic [CW-1:0]    chunk_q, chunk_d;
    logic [CW-1:0]    index_q, index_d;
    logic             err_q, err_d;

    logic [63:0]      beat_buf [MAX_BURST];

    logic             idx_last;
    logic             rd_req;
    logic             wr_req;

    assign idx_last = (index_q == chunk_q - CW'(1));
    assign rd_req   = (state_q == S_RD_REQ);
    assign wr_req   = (state_q == S_WR_REQ);

    always_comb begin
        logic [16:0] src_room;
        logic [16:0] dst_room;
        logic [16:0] best;
        logic        err_next;
        logic [15:0] rem_next;

        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        index_d     = index_q;
        err_d       = err_q;

        // Beats left before the next 4 KB page on each side (addresses are
        // 8-byte aligned, so this is always at least 1).
        src_room = (17'd4096 - {5'd0, src_q[11:0]}) >> 3;
        dst_room = (17'd4096 - {5'd0, dst_q[11:0]}) >> 3;
        best     = {1'b0, remaining_q};
        if (17'(MAX_BURST) < best) best = 17'(MAX_BURST);
        if (src_room < best)       best = src_room;
        if (dst_room < best)       best = dst_room;

        err_next = err_q | i_resp_mem_err;
        rem_next = remaining_q - 16'(chunk_q);

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    src_d       = i_cmd_src;
                    dst_d       = i_cmd_dst;
                    remaining_d = i_cmd_beats;
                    err_d       = 1'b0;
                    state_d     = (i_cmd_beats == 16'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                chunk_d = CW'(best);
                index_d = '0;
                state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (i_req_mem_ready) begin
                    index_d = '0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (i_resp_mem_valid) begin
                    // A read error does not cut the burst short; the beat is
                    // still buffered and written out.
                    err_d = err_next;
                    if (idx_last) begin
                        index_d = '0;
                        state_d = S_WR_REQ;
                    end else begin
                        index_d = index_q + CW'(1);
                    end
                end
            end
            S_WR_REQ: begin
                if (i_req_mem_ready) begin
                    if (idx_last) begin
                        index_d = '0;
                        state_d = S_WR_RESP;
                    end else begin
                        index_d = index_q + CW'(1);
                    end
                end
            end
            S_WR_RESP: begin
                if (i_resp_mem_valid) begin
                    err_d       = err_next;
                    src_d       = src_q + abits'({chunk_q, 3'b000});
                    dst_d       = dst_q + abits'({chunk_q, 3'b000});
                    remaining_d = rem_next;
                    state_d     = ((rem_next == 16'd0) || err_next) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            chunk_q     <= '0;
            index_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            index_q     <= index_d;
            err_q       <= err_d;
        end
    end

    // Beat buffer holds data only; its contents are meaningless after reset.
    always_ff @(posedge i_clk) begin
        if ((state_q == S_RD_DATA) && i_resp_mem_valid) begin
            beat_buf[index_q[CW-2:0]] <= i_resp_mem_data;
        end
    end

    assign o_cmd_ready      = (state_q == S_IDLE);
    assign o_busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done           = (state_q == S_DONE);
    assign o_err            = err_q;

    // Request fields are derived from registered state only, so they stay
    // stable for as long as the bridge withholds ready.
    assign o_req_mem_valid  = rd_req | wr_req;
    assign o_req_mem_write  = wr_req;
    assign o_req_mem_addr   = rd_req ? src_q : (wr_req ? dst_q : '0);
    assign o_req_mem_size   = 3'd3;
    assign o_req_mem_len    = (rd_req | wr_req) ? 8'(chunk_q - CW'(1)) : 8'd0;
    assign o_req_mem_wdata  = wr_req ? beat_buf[index_q[CW-2:0]] : 64'd0;
    assign o_req_mem_wstrb  = wr_req ? 8'hFF : 8'h00;
    assign o_req_mem_last   = wr_req & idx_last;
    assign o_resp_mem_ready = (state_q == S_RD_DATA) || (state_q == S_WR_RESP);

endmodule

// File: tb/tb_dma_copy_seq.sv
// -----------------------------------------------------------------------------
// tb_dma_copy_seq
//   Self-checking bench for dma_copy_seq. The bench plays the bridge: it
//   answers read bursts with address-derived data, randomly stalls ready and
//   response valid, and checks every request handshake against a burst plan
//   computed from the page/size rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_dma_copy_seq;
    localparam int AB = 48;
    localparam int MB = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AB-1:0] i_cmd_src;
    logic [AB-1:0] i_cmd_dst;
    logic [15:0]   i_cmd_beats;
    logic          o_busy, o_done, o_err;
    logic          o_req_mem_valid;
    logic          i_req_mem_ready;
    logic          o_req_mem_write;
    logic [AB-1:0] o_req_mem_addr;
    logic [2:0]    o_req_mem_size;
    logic [7:0]    o_req_mem_len;
    logic [63:0]   o_req_mem_wdata;
    logic [7:0]    o_req_mem_wstrb;
    logic          o_req_mem_last;
    logic          i_resp_mem_valid;
    logic [63:0]   i_resp_mem_data;
    logic          i_resp_mem_err;
    logic          o_resp_mem_ready;

    dma_copy_seq #(.abits(AB), .MAX_BURST(MB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_src(i_cmd_src), .i_cmd_dst(i_cmd_dst), .i_cmd_beats(i_cmd_beats),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_req_mem_valid(o_req_mem_valid), .i_req_mem_ready(i_req_mem_ready),
        .o_req_mem_write(o_req_mem_write), .o_req_mem_addr(o_req_mem_addr),
        .o_req_mem_size(o_req_mem_size), .o_req_mem_len(o_req_mem_len),
        .o_req_mem_wdata(o_req_mem_wdata), .o_req_mem_wstrb(o_req_mem_wstrb),
        .o_req_mem_last(o_req_mem_last),
        .i_resp_mem_valid(i_resp_mem_valid), .i_resp_mem_data(i_resp_mem_data),
        .i_resp_mem_err(i_resp_mem_err), .o_resp_mem_ready(o_resp_mem_ready)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    typedef struct { logic [47:0] src; logic [47:0] dst; int c; } burst_t;
    typedef struct { logic [63:0] data; logic err; logic ack; } resp_t;

    burst_t      exp_q[$];
    burst_t      cur;
    resp_t       rq[$];
    int          ready_pct = 100;
    int          resp_pct  = 100;
    int          err_beat  = -1;
    int          rd_beat_cnt;
    bit          cur_err;
    int          wr_idx;
    int          wr_total;
    int          done_lat;
    logic [31:0] seed;
    logic [47:0] rd_addr_log[$];
    int          rd_len_log[$];
    logic [47:0] wr_addr_log[$];

    function automatic logic [63:0] mdata(input logic [47:0] a);
        return {a[31:0] ^ seed, ~a[47:16]};
    endfunction

    // Burst plan straight from the splitting rules; stops after the burst
    // that carries the injected read error.
    function automatic int plan(input logic [47:0] s, input logic [47:0] d,
                                input int beats, input int eb);
        int rem = beats;
        int start = 0;
        int tot = 0;
        int c, room;
        exp_q.delete();
        while (rem > 0) begin
            c = (rem > MB) ? MB : rem;
            room = (4096 - int'(s[11:0])) / 8;
            if (room < c) c = room;
            room = (4096 - int'(d[11:0])) / 8;
            if (room < c) c = room;
            exp_q.push_back('{s, d, c});
            tot += c;
            if (eb >= start && eb < start + c) break;
            start += c;
            s   += 48'(c * 8);
            d   += 48'(c * 8);
            rem -= c;
        end
        return tot;
    endfunction

    // Bridge model plus per-handshake comparison.
    initial begin
        logic          prev_stall;
        logic [47:0]   snap_addr;
        logic [63:0]   snap_wdata;
        logic [10:0]   snap_ctrl;
        logic          rdy;
        resp_t         r;
        prev_stall       = 1'b0;
        i_req_mem_ready  = 1'b0;
        i_resp_mem_valid = 1'b0;
        i_resp_mem_data  = '0;
        i_resp_mem_err   = 1'b0;
        forever begin
            @(posedge i_clk);
            #2;
            if (i_rst) begin
                rq.delete();
                prev_stall       = 1'b0;
                i_req_mem_ready  = 1'b0;
                i_resp_mem_valid = 1'b0;
                i_resp_mem_err   = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(o_req_mem_valid), 64'd1);
                chk("stall_addr", 64'(o_req_mem_addr), 64'(snap_addr));
                chk("stall_ctrl", 64'({o_req_mem_write, o_req_mem_len, o_req_mem_last, o_req_mem_wstrb[0]}),
                    64'(snap_ctrl));
                chk("stall_wdata", o_req_mem_wdata, snap_wdata);
            end
            // responses queued in earlier cycles only
            if (rq.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
                i_resp_mem_valid = 1'b1;
                i_resp_mem_data  = rq[0].data;
                i_resp_mem_err   = rq[0].err;
                if (o_resp_mem_ready) begin
                    r = rq.pop_front();
                    if (r.ack && cur_err) exp_q.delete();
                end
            end else begin
                i_resp_mem_valid = 1'b0;
                i_resp_mem_data  = {$urandom, $urandom};
                i_resp_mem_err   = 1'b0;
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            i_req_mem_ready = rdy;
            if (o_req_mem_valid && rdy) begin
                if (!o_req_mem_write) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_read", 64'(o_req_mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rd_addr", 64'(o_req_mem_addr), 64'(cur.src));
                        chk("rd_len", 64'(o_req_mem_len), 64'(cur.c - 1));
                        chk("rd_size", 64'(o_req_mem_size), 64'd3);
                        chk("rd_wstrb", 64'(o_req_mem_wstrb), 64'd0);
                        rd_addr_log.push_back(o_req_mem_addr);
                        rd_len_log.push_back(int'(o_req_mem_len));
                        wr_idx  = 0;
                        cur_err = 1'b0;
                        for (int i = 0; i < cur.c; i++) begin
                            r.data = mdata(cur.src + 48'(i * 8));
                            r.err  = (rd_beat_cnt == err_beat);
                            r.ack  = 1'b0;
                            if (r.err) cur_err = 1'b1;
                            rq.push_back(r);
                            rd_beat_cnt++;
                        end
                    end
                end else begin
                    chk("wr_addr", 64'(o_req_mem_addr), 64'(cur.dst));
                    chk("wr_len", 64'(o_req_mem_len), 64'(cur.c - 1));
                    chk("wr_data", o_req_mem_wdata, mdata(cur.src + 48'(wr_idx * 8)));
                    chk("wr_last", 64'(o_req_mem_last), 64'(wr_idx == cur.c - 1));
                    chk("wr_wstrb", 64'(o_req_mem_wstrb), 64'hFF);
                    if (wr_idx == 0) wr_addr_log.push_back(o_req_mem_addr);
                    wr_idx++;
                    wr_total++;
                    if (wr_idx == cur.c) begin
                        r.data = '0;
                        r.err  = 1'b0;
                        r.ack  = 1'b1;
                        rq.push_back(r);
                    end
                end
            end
            prev_stall = o_req_mem_valid && !rdy;
            snap_addr  = o_req_mem_addr;
            snap_wdata = o_req_mem_wdata;
            snap_ctrl  = {o_req_mem_write, o_req_mem_len, o_req_mem_last, o_req_mem_wstrb[0]};
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_err"}, 64'(o_err), 64'd0);
        chk({tag, "_req_valid"}, 64'(o_req_mem_valid), 64'd0);
        chk({tag, "_resp_ready"}, 64'(o_resp_mem_ready), 64'd0);
        chk({tag, "_req_fields"}, 64'({o_req_mem_write, o_req_mem_len, o_req_mem_last, o_req_mem_wstrb}), 64'd0);
        chk({tag, "_req_addr"}, 64'(o_req_mem_addr), 64'd0);
        chk({tag, "_req_wdata"}, o_req_mem_wdata, 64'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        rd_addr_log.delete();
        rd_len_log.delete();
        wr_addr_log.delete();
        rd_beat_cnt = 0;
        wr_total    = 0;
        wr_idx      = 0;
        cur_err     = 1'b0;
        cur         = '{48'd0, 48'd0, 0};
    endtask

    // Waits for ready and issues one command; returns with the accept edge
    // just passed (sampling point #1 after it).
    task automatic issue(input logic [47:0] s, input logic [47:0] d, input int beats);
        int n = 0;
        while (!o_cmd_ready && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("cmd_ready_wait", 64'(o_cmd_ready), 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_src   = s;
        i_cmd_dst   = d;
        i_cmd_beats = 16'(beats);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [47:0] s, input logic [47:0] d, input int beats,
                           input int eb, input int rp, input int vp);
        int exp_tot;
        int cyc;
        bit exp_err;
        clear_model();
        seed      = $urandom;
        err_beat  = eb;
        ready_pct = rp;
        resp_pct  = vp;
        exp_tot   = plan(s, d, beats, eb);
        exp_err   = (eb >= 0 && eb < beats);
        issue(s, d, beats);
        cyc = 1;
        chk("busy_after_accept", 64'(o_busy), 64'(beats != 0));
        while (!o_done && cyc < 20000) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        done_lat = cyc;
        chk("done_seen", 64'(o_done), 64'd1);
        chk("done_err", 64'(o_err), 64'(exp_err));
        chk("done_busy", 64'(o_busy), 64'd0);
        chk("bursts_left", 64'(exp_q.size()), 64'd0);
        chk("beats_written", 64'(wr_total), 64'(exp_tot));
        @(posedge i_clk); #1;
        chk("done_pulse", 64'(o_done), 64'd0);
        chk("ready_after_done", 64'(o_cmd_ready), 64'd1);
        chk("err_held", 64'(o_err), 64'(exp_err));
        $display("cmd src=%h dst=%h beats=%0d err_beat=%0d bursts=%0d beats_wr=%0d cycles=%0d",
                 s, d, beats, eb, rd_addr_log.size(), wr_total, cyc);
    endtask

    initial begin
        logic [47:0] s, d;
        int          b, eb;
        bit          found;
        i_rst       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_src   = '0;
        i_cmd_dst   = '0;
        i_cmd_beats = '0;
        clear_model();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset("reset");
        i_rst = 1'b0;

        // single short burst
        run_cmd(48'h1000, 48'h2000, 4, -1, 100, 100);
        chk("t1_nrd", 64'(rd_addr_log.size()), 64'd1);
        if (rd_addr_log.size() == 1) begin
            chk("t1_rd_addr", 64'(rd_addr_log[0]), 64'h1000);
            chk("t1_rd_len", 64'(rd_len_log[0]), 64'd3);
            chk("t1_wr_addr", 64'(wr_addr_log[0]), 64'h2000);
        end
        chk("t1_beats", 64'(wr_total), 64'd4);

        // split by burst length
        run_cmd(48'h1000, 48'h5000, 40, -1, 100, 100);
        chk("t2_nrd", 64'(rd_addr_log.size()), 64'd3);
        if (rd_addr_log.size() == 3 && wr_addr_log.size() == 3) begin
            chk("t2_rd0", 64'(rd_addr_log[0]), 64'h1000);
            chk("t2_rd1", 64'(rd_addr_log[1]), 64'h1080);
            chk("t2_rd2", 64'(rd_addr_log[2]), 64'h1100);
            chk("t2_len0", 64'(rd_len_log[0]), 64'd15);
            chk("t2_len2", 64'(rd_len_log[2]), 64'd7);
            chk("t2_wr2", 64'(wr_addr_log[2]), 64'h5100);
        end

        // split at a source 4 KB boundary
        run_cmd(48'h0FF0, 48'h3000, 8, -1, 100, 100);
        chk("t3_nrd", 64'(rd_addr_log.size()), 64'd2);
        if (rd_addr_log.size() == 2 && wr_addr_log.size() == 2) begin
            chk("t3_rd0", 64'(rd_addr_log[0]), 64'h0FF0);
            chk("t3_len0", 64'(rd_len_log[0]), 64'd1);
            chk("t3_rd1", 64'(rd_addr_log[1]), 64'h1000);
            chk("t3_len1", 64'(rd_len_log[1]), 64'd5);
            chk("t3_wr1", 64'(wr_addr_log[1]), 64'h3010);
        end

        // zero-length command
        run_cmd(48'h2000, 48'h4000, 0, -1, 100, 100);
        chk("t4_nrd", 64'(rd_addr_log.size()), 64'd0);
        chk("t4_latency_le3", 64'(done_lat <= 3), 64'd1);

        // read error on the third beat of the first burst
        run_cmd(48'h1000, 48'h2000, 32, 2, 100, 100);
        chk("t5_nrd", 64'(rd_addr_log.size()), 64'd1);
        chk("t5_beats", 64'(wr_total), 64'd16);

        // address wrap at the top of the address space
        run_cmd(48'hFFFF_FFFF_FFF0, 48'h8000, 4, -1, 70, 70);
        chk("t6_nrd", 64'(rd_addr_log.size()), 64'd2);
        if (rd_addr_log.size() == 2) begin
            chk("t6_rd1", 64'(rd_addr_log[1]), 64'h0);
        end

        // randomized commands with stalls
        for (int i = 0; i < 20; i++) begin
            s  = 48'h10_0000 + 48'($urandom_range(0, 7)) * 48'd4096 + 48'($urandom_range(0, 511)) * 48'd8;
            d  = 48'h40_0000 + 48'($urandom_range(0, 7)) * 48'd4096 + 48'($urandom_range(0, 511)) * 48'd8;
            b  = $urandom_range(0, 50);
            eb = ($urandom_range(0, 3) == 0 && b > 0) ? int'($urandom_range(0, b - 1)) : -1;
            run_cmd(s, d, b, eb, $urandom_range(30, 100), $urandom_range(30, 100));
        end

        // reset in the middle of a write burst
        clear_model();
        seed      = $urandom;
        err_beat  = -1;
        ready_pct = 50;
        resp_pct  = 60;
        void'(plan(48'h7000, 48'h9000, 20, -1));
        issue(48'h7000, 48'h9000, 20);
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            if (o_req_mem_valid && o_req_mem_write) found = 1'b1;
            else begin
                @(posedge i_clk); #1;
            end
        end
        chk("reach_wr_req", 64'(found), 64'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check_reset("midrst");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        clear_model();
        $display("reset applied mid write burst");

        // recovery after reset
        run_cmd(48'h1000, 48'h2000, 20, -1, 60, 60);
        chk("t7_nrd", 64'(rd_addr_log.size()), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
